instruction_prefetch_unit: RTL

INSTRUCTION_PREFETCH_UNIT -- requirements
Module: instruction_prefetch_unit

---
 rtl/instruction_prefetch_unit.sv | 103 ++++++++++
 1 files changed

// File: rtl/instruction_prefetch_unit.sv
// Instruction prefetch unit: issues sequential fetches to a synchronous ROM,
// buffers responses in a small circular queue with their PCs, and presents
// the head to decode with a valid/ready handshake. A redirect flushes the
// queue, drops any in-flight response and restarts fetching at the new PC.
module instruction_prefetch_unit #(
    parameter int               WIDTH    = 32,
    parameter int               ADDR_B   = 10,
    parameter int               DEPTH    = 4,
    parameter int unsigned      PC_STEP  = 1,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [WIDTH-1:0]  redirect_pc,
    output logic              imem_req,
    output logic [ADDR_B-1:0] imem_addr,
    input  logic [WIDTH-1:0]  imem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_instr,
    output logic [WIDTH-1:0]  out_pc,
    output logic [WIDTH-1:0]  out_pc_plus,
    output logic [WIDTH-1:0]  pc_debug
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] fetch_pc;
    logic [WIDTH-1:0] inflight_pc;
    logic             inflight;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0] q_instr [DEPTH];
    logic [WIDTH-1:0] q_pc    [DEPTH];

    logic enq;
    logic deq;

    // Issue decision uses registered occupancy only; a dequeue in the same
    // cycle does not open a slot, which keeps the request path short.
    always_comb begin
        imem_req = rst_n && !redirect_valid
                   && ((count + CW'(inflight)) < CW'(DEPTH));
        enq      = inflight && !redirect_valid;
        deq      = out_valid && out_ready && !redirect_valid;
    end

    // Head presentation and debug taps, purely from registers.
    always_comb begin
        imem_addr   = fetch_pc[ADDR_B-1:0];
        out_valid   = (count != '0);
        out_instr   = q_instr[rd_ptr];
        out_pc      = q_pc[rd_ptr];
        out_pc_plus = q_pc[rd_ptr] + WIDTH'(PC_STEP);
        pc_debug    = fetch_pc;
    end

    // Control state: fetch PC, in-flight tracking, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + WIDTH'(PC_STEP);
            end
            if (enq)
                wr_ptr <= wr_ptr + PW'(1);
            if (deq)
                rd_ptr <= rd_ptr + PW'(1);
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage; no reset needed since count gates visibility.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_instr[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]    <= inflight_pc;
        end
    end

endmodule
